// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM decoder: FSM encoding, synchronizer depth and
// the PWM period constant shared with the generator.
package pwm_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHigh = 2'd1,
    StLow  = 2'd2
  } pwm_state_e;

  localparam int unsigned SyncStages = 2;
  localparam int unsigned PwmPeriod  = 16;

endpackage

// File: rtl/pwm_edge_sync.sv
// Synchronizes the asynchronous PWM input and detects rising/falling edges
// on the synchronized level.
module pwm_edge_sync
  import pwm_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic pwm_in,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SyncStages-1:0] sync_q, sync_d;
  logic                  s_prev_q, s_prev_d;

  always_comb begin
    sync_d   = {sync_q[SyncStages-2:0], pwm_in};
    s_prev_d = sync_q[SyncStages-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q   <= '0;
      s_prev_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      s_prev_q <= s_prev_d;
    end
  end

  assign s    = sync_q[SyncStages-1];
  assign rise = s & ~s_prev_q;
  assign fall = ~s & s_prev_q;

endmodule

// File: rtl/pwm_decoder.sv
// Measures high time and period of a PWM input (rising edge to rising edge)
// and flags a line that stops toggling.
module pwm_decoder
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] period,
  output logic             meas_valid,
  output logic             stuck_high,
  output logic             stuck_low
);

  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TimeoutPre = CNT_W'(TIMEOUT - 1);

  logic s, rise, fall, edge_ev, timeout;

  pwm_edge_sync u_edge_sync (
    .clk    (clk),
    .reset  (reset),
    .pwm_in (pwm_in),
    .s      (s),
    .rise   (rise),
    .fall   (fall)
  );

  pwm_state_e       state_q, state_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             meas_valid_q, meas_valid_d;
  logic             stuck_high_q, stuck_high_d;
  logic             stuck_low_q, stuck_low_d;

  assign edge_ev = rise | fall;
  // Fires once, on the cycle the idle counter reaches TIMEOUT; an edge pre-empts it.
  assign timeout = ~edge_ev & (edge_cnt_q == TimeoutPre);

  always_comb begin
    state_d      = state_q;
    per_cnt_d    = per_cnt_q + CNT_W'(1);
    hi_cnt_d     = hi_cnt_q;
    edge_cnt_d   = edge_cnt_q;
    high_time_d  = high_time_q;
    period_d     = period_q;
    meas_valid_d = 1'b0;
    stuck_high_d = stuck_high_q;
    stuck_low_d  = stuck_low_q;

    // The fall cycle is excluded so hi_cnt equals cycles from rise to fall.
    if (rise) begin
      per_cnt_d = CNT_W'(1);
      hi_cnt_d  = CNT_W'(1);
    end else if (state_q == StHigh && !fall) begin
      hi_cnt_d = hi_cnt_q + CNT_W'(1);
    end

    if (edge_ev) begin
      edge_cnt_d   = '0;
      stuck_high_d = 1'b0;
      stuck_low_d  = 1'b0;
    end else if (edge_cnt_q != TimeoutCnt) begin
      edge_cnt_d = edge_cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (rise) state_d = StHigh;
      end
      StHigh: begin
        if (fall) state_d = StLow;
      end
      StLow: begin
        if (rise) begin
          state_d      = StHigh;
          high_time_d  = hi_cnt_q;
          period_d     = per_cnt_q;
          meas_valid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (timeout) begin
      state_d      = StIdle;
      stuck_high_d = s;
      stuck_low_d  = ~s;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      per_cnt_q    <= '0;
      hi_cnt_q     <= '0;
      edge_cnt_q   <= '0;
      high_time_q  <= '0;
      period_q     <= '0;
      meas_valid_q <= 1'b0;
      stuck_high_q <= 1'b0;
      stuck_low_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      per_cnt_q    <= per_cnt_d;
      hi_cnt_q     <= hi_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      high_time_q  <= high_time_d;
      period_q     <= period_d;
      meas_valid_q <= meas_valid_d;
      stuck_high_q <= stuck_high_d;
      stuck_low_q  <= stuck_low_d;
    end
  end

  assign high_time  = high_time_q;
  assign period     = period_q;
  assign meas_valid = meas_valid_q;
  assign stuck_high = stuck_high_q;
  assign stuck_low  = stuck_low_q;

endmodule
